// File: rtl/elastic_pipe_reg.sv
// DEPTH-deep, WIDTH-wide elastic pipeline register with valid/ready handshake,
// synchronous flush and occupancy count. Define ELASTIC_PIPE_SKID_EN for a registered-ready skid entry.
module elastic_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
    $error("elastic_pipe_reg: DEPTH and WIDTH must both be >= 1");
  end

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] stage_ready;
  logic [DEPTH-1:0] inc_valid;
  logic [WIDTH-1:0] inc_data [DEPTH];
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             s0_valid;
  logic [WIDTH-1:0] s0_data;
  logic             in_fire, out_fire;

  // A stage can load if it is empty or everything downstream of it can advance.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc            = acc | !v_q[k];
      stage_ready[k] = acc;
    end
  end

`ifdef ELASTIC_PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign in_ready = !skid_valid_q & !flush;
  assign s0_valid = skid_valid_q | in_valid;
  assign s0_data  = skid_valid_q ? skid_data_q : in_data;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (stage_ready[0]) skid_valid_d = 1'b0;
    end else if (in_fire && !stage_ready[0]) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  assign in_ready = stage_ready[0] & !flush;
  assign s0_valid = in_valid;
  assign s0_data  = in_data;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = v_q[DEPTH-1] & out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    v_d         = v_q;
    data_d      = data_q;
    inc_valid   = '0;
    inc_valid[0] = s0_valid;
    inc_data[0]  = s0_data;
    for (int k = 1; k < DEPTH; k++) begin
      inc_valid[k] = v_q[k-1];
      inc_data[k]  = data_q[k-1];
    end
    if (flush) begin
      v_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (stage_ready[k]) begin
          v_d[k] = inc_valid[k];
          if (inc_valid[k]) data_d[k] = inc_data[k];
        end
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) occ_d = '0;
    else if (in_fire && !out_fire) occ_d = occ_q + 1'b1;
    else if (!in_fire && out_fire) occ_d = occ_q - 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      occ_q <= '0;
      // NOTE: the stage array is plain flops, not RAM, so clearing it on reset is legal and wanted.
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      occ_q  <= occ_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed self-checking bench for elastic_pipe_reg: a DEPTH=2 instance for most
// scenarios and a DEPTH=3 instance for bubble collapse.
module tb_elastic_pipe_reg;
  localparam int W = 32;
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int CAP2 = 3;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP2 = 2;
  localparam bit SKID = 1'b0;
`endif
  localparam logic [W-1:0] BEATS [4] = '{32'hA, 32'hB, 32'hC, 32'hD};

  logic clk, reset, flush;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0] occupancy;
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [W-1:0] c_in_data, c_out_data;
  logic [2:0] c_occupancy;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] got [$];

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs n cycles on the DEPTH=2 instance, recording emitted beats and dropping
  // in_valid once the held producer beat has been accepted.
  task automatic collect(input int n);
    bit accepted;
    got.delete();
    for (int i = 0; i < n; i++) begin
      #1;
      if (out_valid && out_ready) got.push_back(out_data);
      accepted = in_valid && in_ready;
      tick();
      if (accepted) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    compared++; if (out_data !== '0) begin mismatched++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    compared++; if (occupancy !== 2'd0) begin mismatched++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    tick();
    reset = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_in_ready: got %0b want 1", in_ready); end
    tick();
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL stream_latency_early: out_valid got %0b want 0", out_valid); end
    in_data = 32'h22;
    tick();
    compared++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin mismatched++; $display("FAIL stream_beat0: got v=%0b d=%h want v=1 d=11", out_valid, out_data); end
    compared++; if (occupancy !== 2'd2) begin mismatched++; $display("FAIL stream_occ_peak: got %0d want 2", occupancy); end
    in_data = 32'h33;
    tick();
    compared++; if (out_valid !== 1'b1 || out_data !== 32'h22) begin mismatched++; $display("FAIL stream_beat1: got v=%0b d=%h want v=1 d=22", out_valid, out_data); end
    in_valid = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b1 || out_data !== 32'h33 || occupancy !== 2'd1) begin mismatched++; $display("FAIL stream_beat2: got v=%0b d=%h occ=%0d want v=1 d=33 occ=1", out_valid, out_data, occupancy); end
    tick();
    compared++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin mismatched++; $display("FAIL stream_drained: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < CAP2; i++) begin
      in_valid = 1'b1; in_data = BEATS[i];
      #1;
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_accept%0d: in_ready got %0b want 1", i, in_ready); end
      tick();
    end
    in_data = BEATS[CAP2];
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_full_in_ready: got %0b want 0", in_ready); end
    compared++; if (occupancy !== 2'(CAP2)) begin mismatched++; $display("FAIL bp_full_occ: got %0d want %0d", occupancy, CAP2); end
    tick();
    compared++; if (occupancy !== 2'(CAP2) || out_data !== BEATS[0]) begin mismatched++; $display("FAIL bp_hold: got occ=%0d d=%h want occ=%0d d=%h", occupancy, out_data, CAP2, BEATS[0]); end
    out_ready = 1'b1;
    #1;
    compared++; if (in_ready !== !SKID) begin mismatched++; $display("FAIL bp_ready_path: in_ready got %0b want %0b", in_ready, !SKID); end
    collect(8);
    compared++; if (got.size() != CAP2 + 1) begin mismatched++; $display("FAIL bp_count: got %0d beats want %0d", got.size(), CAP2 + 1); end
    for (int i = 0; i < got.size() && i <= CAP2; i++) begin
      compared++; if (got[i] !== BEATS[i]) begin mismatched++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], BEATS[i]); end
    end
    compared++; if (occupancy !== 2'd0) begin mismatched++; $display("FAIL bp_end_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    compared++; if (occupancy !== 2'd2) begin mismatched++; $display("FAIL sim_full_occ: got %0d want 2", occupancy); end
    in_data = 32'h3; out_ready = 1'b1;
    #1;
    compared++; if (in_ready !== 1'b1 || out_data !== 32'h1) begin mismatched++; $display("FAIL sim_same_cycle: got rdy=%0b d=%h want rdy=1 d=1", in_ready, out_data); end
    tick();
    in_valid = 1'b0;
    compared++; if (out_data !== 32'h2 || occupancy !== 2'd2) begin mismatched++; $display("FAIL sim_after: got d=%h occ=%0d want d=2 occ=2", out_data, occupancy); end
    collect(4);
    compared++; if (got.size() != 2 || got[0] !== 32'h2 || got[1] !== 32'h3) begin mismatched++; $display("FAIL sim_tail: got %0d beats first=%h want 2 beats 2,3", got.size(), (got.size() > 0) ? got[0] : 32'h0); end
  endtask

  task automatic test_bubble();
    do_reset();
    c_in_valid = 1'b1; c_in_data = 32'h55;
    tick();
    c_in_valid = 1'b0;
    tick();
    tick();
    compared++; if (c_out_valid !== 1'b1 || c_out_data !== 32'h55 || c_occupancy !== 3'd1) begin mismatched++; $display("FAIL bub_setup: got v=%0b d=%h occ=%0d want v=1 d=55 occ=1", c_out_valid, c_out_data, c_occupancy); end
    c_in_valid = 1'b1; c_in_data = 32'h66;
    #1;
    compared++; if (c_in_ready !== 1'b1) begin mismatched++; $display("FAIL bub_accept: in_ready got %0b want 1", c_in_ready); end
    tick();
    c_in_valid = 1'b0;
    tick();
    tick();
    compared++; if (c_occupancy !== 3'd2 || c_out_data !== 32'h55) begin mismatched++; $display("FAIL bub_collapse: got occ=%0d d=%h want occ=2 d=55", c_occupancy, c_out_data); end
    c_out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (c_out_valid) got.push_back(c_out_data);
      tick();
    end
    compared++; if (got.size() != 2 || got[0] !== 32'h55 || got[1] !== 32'h66) begin mismatched++; $display("FAIL bub_order: got %0d beats first=%h want 2 beats 55,66", got.size(), (got.size() > 0) ? got[0] : 32'h0); end
  endtask

  task automatic test_flush();
    bit seen;
    do_reset();
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    compared++; if (occupancy !== 2'd2) begin mismatched++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    flush = 1'b1; in_data = 32'h77;
    #1;
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    compared++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin mismatched++; $display("FAIL flush_cleared: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    compared++; if (out_data !== 32'h1) begin mismatched++; $display("FAIL flush_data_kept: got %h want 1", out_data); end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL flush_no_emit: out_valid seen=%0b want 0", seen); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h99;
    tick();
    in_valid = 1'b0;
    tick();
    compared++; if (out_valid !== 1'b1 || out_data !== 32'h99) begin mismatched++; $display("FAIL areset_setup: got v=%0b d=%h want v=1 d=99", out_valid, out_data); end
    #2;
    reset = 1'b1;
    #1;
    compared++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin mismatched++; $display("FAIL areset_immediate: got v=%0b d=%h occ=%0d want all 0", out_valid, out_data, occupancy); end
    #2;
    reset = 1'b0;
    tick();
    tick();
    compared++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin mismatched++; $display("FAIL areset_after: got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
